alu_seq_ctrl: RTL and testbench

Front-panel sequencer for the board ALU. Walks the user through loading operand A and operand B from the switches, then selecting an operation with the four op buttons. It then drives the ALU, waits the ALU latency and holds the captured result for the display. Sits between the raw board inputs (switches, buttons) and the ALU/display datapath.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/btn_edge.sv | 38 +++
 rtl/alu_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the front-panel ALU sequencer: op codes, FSM states,
// and the one-hot button decoder.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SUB = 3'd4
  } op_t;

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_SEL_OP = 3'd2,
    S_EXEC   = 3'd3,
    S_SHOW   = 3'd4
  } state_t;

  // True when exactly one of the four op buttons is held
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Map a one-hot op button vector to its op code; anything else is OP_NOP
  function automatic op_t btns_to_op(input logic [3:0] v);
    case (v)
      4'b0001: return OP_ADD;
      4'b0010: return OP_AND;
      4'b0100: return OP_OR;
      4'b1000: return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus rising-edge pulse generator for N raw buttons.
// Edges are suppressed until the synchronizer has refilled after reset, so a
// button held through reset never produces a pulse.
module btn_edge #(
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] i_raw,
  output logic [N-1:0] o_level,
  output logic [N-1:0] o_pulse
);

  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;
  logic [N-1:0] r_prev;
  logic [2:0]   r_arm;

  // Synchronize raw levels, remember previous level, count settle cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_arm   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_arm   <= {r_arm[1:0], 1'b1};
    end
  end

  // r_prev only holds a real sampled level once r_arm[2] is set
  assign o_level = r_sync2;
  assign o_pulse = r_sync2 & ~r_prev & {N{r_arm[2]}};

endmodule

// File: rtl/alu_seq_ctrl.sv
// Front-panel sequencer: load A, load B, pick an op, run the ALU for
// ALU_LAT cycles, then hold the captured result for display.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic [3:0]       btns,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [WIDTH-1:0] display_val,
  output logic [2:0]       state_dbg
);

  localparam int unsigned    CW   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(ALU_LAT - 1);

  state_t           r_state;
  op_t              r_alu_op;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sw_s1;
  logic [WIDTH-1:0] r_sw_s2;

  logic [3:0]       w_btn_level;
  logic [3:0]       w_btn_pulse;
  logic [0:0]       w_enter_level;
  logic [0:0]       w_enter_pulse;
  logic             w_enter;
  logic             w_op_sel;
  op_t              w_op_code;

  btn_edge #(.N(4)) u_btns (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (btns),
    .o_level (w_btn_level),
    .o_pulse (w_btn_pulse)
  );

  btn_edge #(.N(1)) u_enter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (btn_enter),
    .o_level (w_enter_level),
    .o_pulse (w_enter_pulse)
  );

  assign w_enter   = w_enter_pulse[0] & w_enter_level[0];
  assign w_op_sel  = (|w_btn_pulse) && is_onehot4(w_btn_level);
  assign w_op_code = btns_to_op(w_btn_level);

  // Two-flop synchronizer for the operand switches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Sequencer FSM with registered operand/op/result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_LOAD_A;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_alu_op <= OP_NOP;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_LOAD_A: begin
          if (w_enter) begin
            r_op_a  <= r_sw_s2;
            r_state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (w_enter) begin
            r_op_b  <= r_sw_s2;
            r_state <= S_SEL_OP;
          end
        end
        S_SEL_OP: begin
          if (w_op_sel) begin
            r_alu_op <= w_op_code;
            r_cnt    <= '0;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == LAST) begin
            r_result <= alu_result;
            r_valid  <= 1'b1;
            r_state  <= S_SHOW;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (w_op_sel) begin
            r_alu_op <= w_op_code;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_EXEC;
          end else if (w_enter) begin
            r_alu_op <= OP_NOP;
            r_valid  <= 1'b0;
            r_state  <= S_LOAD_A;
          end
        end
        default: r_state <= S_LOAD_A;
      endcase
    end
  end

  // Display source follows the step the user is on
  always_comb begin
    display_val = r_sw_s2;
    case (r_state)
      S_SEL_OP, S_EXEC: display_val = r_op_b;
      S_SHOW:           display_val = r_result;
      default:          display_val = r_sw_s2;
    endcase
  end

  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign alu_op       = r_alu_op;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed front-panel scenarios with literal checks,
// then random button/switch activity, all compared each cycle against a
// behavioural model of the sequencer.
module tb_alu_seq_ctrl;

  localparam int WIDTH   = 8;
  localparam int ALU_LAT = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] sw = '0;
  logic             btn_enter = 1'b0;
  logic [3:0]       btns = '0;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] op_a, op_b, result, display_val;
  logic [2:0]       alu_op, state_dbg;
  logic             result_valid;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sw           (sw),
    .btn_enter    (btn_enter),
    .btns         (btns),
    .alu_result   (alu_result),
    .op_a         (op_a),
    .op_b         (op_b),
    .alu_op       (alu_op),
    .result       (result),
    .result_valid (result_valid),
    .display_val  (display_val),
    .state_dbg    (state_dbg)
  );

  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input int op);
    case (op)
      1: return a + b;
      2: return a & b;
      3: return a | b;
      4: return a - b;
      default: return '0;
    endcase
  endfunction

  // ALU stand-in with ALU_LAT-1 register stages: a result is only correct
  // when sampled ALU_LAT edges after the operands settle.
  logic [WIDTH-1:0] alu_pipe [ALU_LAT-1];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(op_a, op_b, int'(alu_op));
    for (int i = 1; i < ALU_LAT - 1; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[ALU_LAT-2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: step number (0..4), operands, op, result, and
  // raw-input history (a press is seen two edges after it is sampled).
  int               m_st = 0, m_op = 0, m_remain = 0, m_edges = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic             m_rv = 1'b0;
  logic [4:0]       h1 = '0, h2 = '0, h3 = '0;
  logic [WIDTH-1:0] s1 = '0, s2 = '0;
  logic [4:0]       m_pulse;
  logic             m_enter, m_opv;
  int               m_code;

  task automatic model_step();
    if (!reset_n) begin
      m_st = 0; m_op = 0; m_remain = 0; m_edges = 0;
      m_a = '0; m_b = '0; m_res = '0; m_rv = 1'b0;
      h1 = '0; h2 = '0; h3 = '0; s1 = '0; s2 = '0;
      return;
    end
    m_pulse = (m_edges >= 3) ? (h2 & ~h3) : 5'b0;
    m_enter = m_pulse[4];
    m_opv   = (m_pulse[3:0] != 4'd0) && ($countones(h2[3:0]) == 1);
    m_code  = 0;
    for (int i = 0; i < 4; i++) if (h2[i]) m_code = i + 1;
    case (m_st)
      0: if (m_enter) begin m_a = s2; m_st = 1; end
      1: if (m_enter) begin m_b = s2; m_st = 2; end
      2: if (m_opv) begin m_op = m_code; m_remain = ALU_LAT; m_st = 3; end
      3: begin
        m_remain--;
        if (m_remain == 0) begin
          m_res = alu_f(m_a, m_b, m_op); m_rv = 1'b1; m_st = 4;
        end
      end
      default: begin
        if (m_opv) begin
          m_op = m_code; m_rv = 1'b0; m_remain = ALU_LAT; m_st = 3;
        end else if (m_enter) begin
          m_op = 0; m_rv = 1'b0; m_st = 0;
        end
      end
    endcase
    h3 = h2; h2 = h1; h1 = {btn_enter, btns};
    s2 = s1; s1 = sw;
    if (m_edges < 10) m_edges++;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("state_dbg", state_dbg, m_st);
    chk("op_a", op_a, m_a);
    chk("op_b", op_b, m_b);
    chk("alu_op", alu_op, m_op);
    chk("result", result, m_res);
    chk("result_valid", result_valid, m_rv);
    if (m_st <= 1)      chk("display_sw", display_val, s2);
    else if (m_st == 2) chk("display_opb", display_val, m_b);
    else if (m_st == 4) chk("display_res", display_val, m_res);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_enter();
    btn_enter = 1'b1; tick(2); btn_enter = 1'b0; tick(4);
  endtask

  task automatic press_btns(input logic [3:0] v);
    btns = v; tick(2); btns = 4'd0; tick(4);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (state_dbg !== 3'(s) && n < budget) begin @(negedge clk); n++; end
    chk(name, state_dbg, s);
  endtask

  task automatic load_ab(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    sw = a; tick(3); press_enter();
    sw = b; tick(3); press_enter();
  endtask

  initial begin
    int n, trans, bad_st;
    logic [2:0] prev_st;

    // Reset values
    tick(3);
    chk("rst_state", state_dbg, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    reset_n = 1'b1;
    tick(4);

    // A=12, B=05, ADD; raw press to valid = 2 sync + 1 edge + ALU_LAT
    load_ab(8'h12, 8'h05);
    chk("ld_state", state_dbg, 2);
    chk("ld_op_a", op_a, 8'h12);
    chk("ld_op_b", op_b, 8'h05);
    btns = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (result_valid !== 1'b1 && n < 40);
    btns = 4'd0;
    chk("add_latency", n, 7);
    chk("add_result", result, 8'h17);
    chk("add_alu_op", alu_op, 3'b001);
    chk("add_state", state_dbg, 4);
    tick(4);
    press_enter();
    chk("back_state", state_dbg, 0);
    chk("back_alu_op", alu_op, 0);
    chk("back_op_a", op_a, 8'h12);

    // Multi-hot ignored, then SUB
    load_ab(8'h12, 8'h05);
    press_btns(4'b0011);
    chk("multihot_state", state_dbg, 2);
    chk("multihot_alu_op", alu_op, 0);
    press_btns(4'b1000);
    chk("sub_state", state_dbg, 3);
    chk("sub_alu_op", alu_op, 3'b100);
    wait_state(4, 20, "sub_done");
    chk("sub_result", result, 8'h0D);
    press_enter();

    // Enter and OR in the same cycle: op wins
    load_ab(8'h3C, 8'h0F);
    btn_enter = 1'b1; btns = 4'b0100; tick(2);
    btn_enter = 1'b0; btns = 4'd0; tick(4);
    wait_state(4, 20, "or_done");
    chk("or_alu_op", alu_op, 3'b011);
    chk("or_result", result, 8'h3F);
    chk("or_op_b", op_b, 8'h0F);

    // Re-execute from SHOW with AND
    btns = 4'b0010;
    n = 0;
    while (result_valid !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    btns = 4'd0;
    chk("reexec_valid_drop", result_valid, 0);
    chk("reexec_alu_op", alu_op, 3'b010);
    n = 0;
    while (result_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("and_result", result, 8'h0C);
    press_enter();
    chk("and_exit_state", state_dbg, 0);
    chk("and_exit_valid", result_valid, 0);
    chk("and_exit_op_a", op_a, 8'h3C);

    // Enter held 50 cycles: a single step
    sw = 8'h55; tick(3);
    btn_enter = 1'b1;
    trans = 0; prev_st = state_dbg;
    repeat (50) begin
      @(negedge clk);
      if (state_dbg != prev_st) trans++;
      prev_st = state_dbg;
    end
    btn_enter = 1'b0; tick(4);
    chk("hold_transitions", trans, 1);
    chk("hold_state", state_dbg, 1);
    chk("hold_op_a", op_a, 8'h55);

    // Async reset mid-EXEC with buttons held through release
    sw = 8'h0A; tick(3); press_enter();
    btns = 4'b0001;
    n = 0;
    while (state_dbg !== 3'd3 && n < 20) begin @(negedge clk); n++; end
    chk("exec_reached", state_dbg, 3);
    tick(2);
    btn_enter = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("async_state", state_dbg, 0);
    chk("async_op_a", op_a, 0);
    chk("async_op_b", op_b, 0);
    chk("async_alu_op", alu_op, 0);
    chk("async_valid", result_valid, 0);
    tick(3);
    reset_n = 1'b1;
    bad_st = 0;
    repeat (12) begin @(negedge clk); if (state_dbg != 3'd0) bad_st++; end
    chk("held_no_pulse", bad_st, 0);
    btns = 4'd0; btn_enter = 1'b0; tick(6);
    chk("release_state", state_dbg, 0);

    // Random front-panel activity
    for (int it = 0; it < 300; it++) begin
      if (it % 97 == 50) begin
        @(negedge clk); #3 reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
      end
      case ($urandom_range(0, 4))
        0: begin sw = WIDTH'($urandom); tick($urandom_range(1, 3)); end
        1: begin
          btn_enter = 1'b1; tick($urandom_range(1, 5));
          btn_enter = 1'b0; tick($urandom_range(1, 4));
        end
        2: begin
          btns = 4'($urandom); tick($urandom_range(1, 5));
          btns = 4'd0; tick($urandom_range(1, 4));
        end
        3: begin
          btns = 4'd1 << $urandom_range(0, 3); tick($urandom_range(1, 5));
          btns = 4'd0; tick($urandom_range(1, 8));
        end
        default: begin
          btn_enter = 1'b1; btns = 4'($urandom); tick($urandom_range(1, 4));
          btn_enter = 1'b0; btns = 4'd0; tick($urandom_range(1, 4));
        end
      endcase
    end
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
